// File: rtl/window_seq_ctrl.sv
// Sequencer for the radar noise-reducer sliding window: feeds points into the window buffer,
// kicks the filter once per complete window, pads/clears at end of frame.
module window_seq_ctrl #(
  parameter int PT_W    = 128,
  parameter int WIN_LEN = 5,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [PT_W-1:0]  s_point_i,
  input  logic             s_last_i,
  output logic             buf_shift_o,
  output logic [PT_W-1:0]  buf_point_o,
  output logic             buf_clear_o,
  output logic             filt_start_o,
  input  logic             filt_done_i,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] win_count_o,
  output logic             err_timeout_o,
  output logic             err_spurious_o
);

  localparam int HALF = WIN_LEN / 2;
  localparam int FW   = $clog2(WIN_LEN + 1);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] WIN_C    = FW'(WIN_LEN);
  localparam logic [FW-1:0] HALF_C   = FW'(HALF);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ACCEPT, FILTER, DRAIN, CLEAR} state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d, pad_q, pad_d, fill_nxt;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             tmo_err_q, tmo_err_d, spur_q, spur_d;
  logic             start_q, fdone_q;

  // fill_cnt saturates so every shift after the first full window completes a new window
  assign fill_nxt = (fill_q == WIN_C) ? fill_q : fill_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    pad_d       = pad_q;
    tmo_d       = '0;
    last_d      = last_q;
    win_d       = win_q;
    tmo_err_d   = tmo_err_q;
    spur_d      = spur_q | (filt_done_i & (state_q != FILTER));
    s_ready_o   = (state_q == ACCEPT);
    buf_shift_o = 1'b0;
    buf_point_o = s_point_i;
    buf_clear_o = 1'b0;
    case (state_q)
      ACCEPT: begin
        buf_shift_o = s_valid_i;
        if (s_valid_i) begin
          fill_d = fill_nxt;
          last_d = s_last_i;
          if (fill_q == '0) win_d = '0;
          if (fill_nxt == WIN_C)  state_d = FILTER;
          else if (s_last_i)      state_d = (HALF > 0) ? DRAIN : CLEAR;
        end
      end
      FILTER: begin
        tmo_d = tmo_q + 1'b1;
        if (filt_done_i || tmo_q == TMO_LAST) begin
          if (tmo_q == TMO_LAST) tmo_err_d = 1'b1;
          if (win_q != '1) win_d = win_q + 1'b1;
          tmo_d = '0;
          if (!last_q)             state_d = ACCEPT;
          else if (pad_q < HALF_C) state_d = DRAIN;
          else                     state_d = CLEAR;
        end
      end
      DRAIN: begin
        buf_shift_o = 1'b1;
        buf_point_o = '1;
        pad_d       = pad_q + 1'b1;
        fill_d      = fill_nxt;
        if (fill_nxt == WIN_C)    state_d = FILTER;
        else if (pad_d == HALF_C) state_d = CLEAR;
      end
      CLEAR: begin
        buf_clear_o = ~rst;
        fill_d      = '0;
        pad_d       = '0;
        last_d      = 1'b0;
        state_d     = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCEPT;
      fill_q    <= '0;
      pad_q     <= '0;
      tmo_q     <= '0;
      last_q    <= 1'b0;
      win_q     <= '0;
      tmo_err_q <= 1'b0;
      spur_q    <= 1'b0;
      start_q   <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      pad_q     <= pad_d;
      tmo_q     <= tmo_d;
      last_q    <= last_d;
      win_q     <= win_d;
      tmo_err_q <= tmo_err_d;
      spur_q    <= spur_d;
      start_q   <= (state_d == FILTER) && (state_q != FILTER);
      fdone_q   <= (state_q == CLEAR);
    end
  end

  assign filt_start_o   = start_q;
  assign frame_done_o   = fdone_q;
  assign win_count_o    = win_q;
  assign err_timeout_o  = tmo_err_q;
  assign err_spurious_o = spur_q;

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Directed bench for window_seq_ctrl: frame sizes, padding, timeout, spurious done and reset.
module tb_window_seq_ctrl;
  localparam int PT_W = 128;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [PT_W-1:0]  s_point = '0;
  logic             s_last = 1'b0;
  logic             buf_shift;
  logic [PT_W-1:0]  buf_point;
  logic             buf_clear;
  logic             filt_start;
  logic             filt_done;
  logic             frame_done;
  logic [CNT_W-1:0] win_count;
  logic             err_timeout;
  logic             err_spurious;

  logic auto_en = 1'b0;
  logic auto_done = 1'b0;
  logic spur_done = 1'b0;
  int   dcnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  int data_tot = 0, pad_tot = 0, start_tot = 0, clear_tot = 0, fdone_tot = 0, pads_at_start = 0;

  assign filt_done = auto_done | spur_done;

  always #5 clk = ~clk;

  window_seq_ctrl #(.PT_W(PT_W), .WIN_LEN(5), .TIMEOUT(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_point_i(s_point), .s_last_i(s_last),
    .buf_shift_o(buf_shift), .buf_point_o(buf_point), .buf_clear_o(buf_clear),
    .filt_start_o(filt_start), .filt_done_i(filt_done), .frame_done_o(frame_done),
    .win_count_o(win_count), .err_timeout_o(err_timeout), .err_spurious_o(err_spurious)
  );

  always @(negedge clk) begin
    if (buf_shift && buf_point == {PT_W{1'b1}}) pad_tot++;
    else if (buf_shift) data_tot++;
    if (buf_clear) clear_tot++;
    if (frame_done) fdone_tot++;
    if (filt_start) begin
      start_tot++;
      pads_at_start = pad_tot;
    end
  end

  // Filter model: answers filt_done three cycles after each filt_start.
  always @(posedge clk) begin
    #1;
    auto_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && auto_en) auto_done = 1'b1;
    end
    if (filt_start && auto_en) dcnt = 3;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t;
      s_valid = 1'b1;
      s_point = PT_W'(i + 1);
      s_last  = with_last && (i == n - 1);
      t = 0;
      while (!s_ready && t < 3000) begin
        tick();
        t++;
      end
      check_eq("beat_wait", 32'(s_ready), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_fdone(input int target);
    int t;
    t = 0;
    while (fdone_tot < target && t < 3000) begin
      tick();
      t++;
    end
    check_eq("fdone_wait", 32'(fdone_tot), 32'(target));
  endtask

  initial begin
    int b_data, b_pad, b_start, b_clear, b_fd, cnt;
    logic pre_err;

    tick();
    tick();
    check_eq("rst_ready", 32'(s_ready), 32'd1);
    check_eq("rst_clear", 32'(buf_clear), 32'd0);
    check_eq("rst_start", 32'(filt_start), 32'd0);
    check_eq("rst_fdone", 32'(frame_done), 32'd0);
    check_eq("rst_win", 32'(win_count), 32'd0);
    check_eq("rst_terr", 32'(err_timeout), 32'd0);
    check_eq("rst_serr", 32'(err_spurious), 32'd0);
    rst = 1'b0;
    tick();

    // N=10: 8 windows, 2 pads
    auto_en = 1'b1;
    b_data = data_tot; b_pad = pad_tot; b_start = start_tot; b_clear = clear_tot; b_fd = fdone_tot;
    send_frame(10, 1'b1);
    wait_fdone(b_fd + 1);
    check_eq("n10_data", 32'(data_tot - b_data), 32'd10);
    check_eq("n10_pads", 32'(pad_tot - b_pad), 32'd2);
    check_eq("n10_starts", 32'(start_tot - b_start), 32'd8);
    check_eq("n10_clears", 32'(clear_tot - b_clear), 32'd1);
    check_eq("n10_win", 32'(win_count), 32'd8);
    check_eq("n10_errs", 32'({err_timeout, err_spurious}), 32'd0);

    // N=2: no window at all
    b_data = data_tot; b_pad = pad_tot; b_start = start_tot; b_clear = clear_tot; b_fd = fdone_tot;
    send_frame(2, 1'b1);
    wait_fdone(b_fd + 1);
    check_eq("n2_data", 32'(data_tot - b_data), 32'd2);
    check_eq("n2_pads", 32'(pad_tot - b_pad), 32'd2);
    check_eq("n2_starts", 32'(start_tot - b_start), 32'd0);
    check_eq("n2_clears", 32'(clear_tot - b_clear), 32'd1);
    check_eq("n2_win", 32'(win_count), 32'd0);

    // N=3: single window after the second pad
    b_pad = pad_tot; b_start = start_tot; b_fd = fdone_tot;
    send_frame(3, 1'b1);
    wait_fdone(b_fd + 1);
    check_eq("n3_starts", 32'(start_tot - b_start), 32'd1);
    check_eq("n3_pad_at_start", 32'(pads_at_start - b_pad), 32'd2);
    check_eq("n3_win", 32'(win_count), 32'd1);

    // Withheld filt_done: timeout after 1024 FILTER cycles
    auto_en = 1'b0;
    send_frame(5, 1'b0);
    cnt = 0;
    pre_err = 1'b1;
    while (!s_ready && cnt < 2000) begin
      tick();
      cnt++;
      if (cnt == 1023) pre_err = err_timeout;
    end
    check_eq("tmo_cycles", 32'(cnt), 32'd1024);
    check_eq("tmo_pre", 32'(pre_err), 32'd0);
    check_eq("tmo_err", 32'(err_timeout), 32'd1);
    check_eq("tmo_win", 32'(win_count), 32'd1);

    // Close that 6-point frame: 4 windows total
    auto_en = 1'b1;
    b_pad = pad_tot; b_start = start_tot; b_fd = fdone_tot;
    send_frame(1, 1'b1);
    wait_fdone(b_fd + 1);
    check_eq("n6_starts", 32'(start_tot - b_start), 32'd3);
    check_eq("n6_pads", 32'(pad_tot - b_pad), 32'd2);
    check_eq("n6_win", 32'(win_count), 32'd4);

    // filt_done while idle in ACCEPT
    auto_en = 1'b0;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    check_eq("spur_err", 32'(err_spurious), 32'd1);
    check_eq("spur_win", 32'(win_count), 32'd4);
    check_eq("spur_terr", 32'(err_timeout), 32'd1);

    // Reset while in FILTER mid-frame
    send_frame(5, 1'b0);
    check_eq("pre_rst_ready", 32'(s_ready), 32'd0);
    repeat (3) tick();
    b_clear = clear_tot;
    rst = 1'b1;
    tick();
    check_eq("mrst_ready", 32'(s_ready), 32'd1);
    check_eq("mrst_win", 32'(win_count), 32'd0);
    check_eq("mrst_errs", 32'({err_timeout, err_spurious}), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("mrst_noclear", 32'(clear_tot - b_clear), 32'd0);

    auto_en = 1'b1;
    b_data = data_tot; b_start = start_tot;
    send_frame(5, 1'b0);
    cnt = 0;
    while (!s_ready && cnt < 2000) begin
      tick();
      cnt++;
    end
    repeat (3) tick();
    check_eq("post_data", 32'(data_tot - b_data), 32'd5);
    check_eq("post_starts", 32'(start_tot - b_start), 32'd1);
    check_eq("post_win", 32'(win_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
